reg_file_write_sched: RTL and testbench
=======================================

REG_FILE_WRITE_SCHED -- requirements
Module: reg_file_write_sched

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, data word width.
REQ-002 SHALL have parameter SELECT_SIZE, default 5, register select width (32 registers).
REQ-003 SHALL have port clk_i  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rst_i  input  1  reset; synchronous, active-high.
REQ-005 SHALL have ports wb0_valid_i, wb1_valid_i  input  1 each  write request valid (port 0 = ALU writeback, port 1 = load writeback).
REQ-006 SHALL have ports wb0_dst_i, wb1_dst_i  input  SELECT_SIZE each  destination register.
REQ-007 SHALL have ports wb0_data_i, wb1_data_i  input  DATA_WIDTH each  write data.
REQ-008 SHALL have ports wb0_ready_o, wb1_ready_o  output  1 each  request accepted when valid and ready are high at a rising edge.
REQ-009 SHALL have port clear_i  input  1  request to zero x1..x31.
REQ-010 SHALL have port reg_we_n_o  output  1  register-file write strobe, active low.
REQ-011 SHALL have ports reg_dst_o (SELECT_SIZE) and reg_data_o (DATA_WIDTH), both output  register-file write address and data.
REQ-012 SHALL have port busy_o  output  1  high while a clear sequence runs.
REQ-013 SHALL have port clear_done_o  output  1  one-cycle pulse at clear completion.

Function
REQ-014 SHALL implement FSM states RUN and CLEAR.
REQ-015 SHALL drive reg_we_n_o, reg_dst_o and reg_data_o from registers only; the register file samples them on the falling edge of the same cycle.
REQ-016 SHALL assert a port's ready only when state = RUN, clear_i = 0, and that port holds the grant.
REQ-017 SHALL grant the only valid port when one port is valid.
REQ-018 SHALL grant the port not granted last when both ports are valid (round-robin); a last-grant pointer updates on every acceptance.
REQ-019 SHALL, on acceptance at edge N, drive the accepted dst/data with reg_we_n_o = 0 during cycle N+1 (latency 1, one write per cycle).
REQ-020 SHALL accept a request with dst = 0 but keep reg_we_n_o = 1 for it, so x0 is never written.
REQ-021 SHALL, in a cycle with no acceptance, drive reg_we_n_o = 1 and hold reg_dst_o/reg_data_o unchanged.
REQ-022 SHALL, on clear_i = 1 in RUN at edge E0, enter CLEAR with index = 1 and accept no request at E0.
REQ-023 SHALL, at each edge in CLEAR, load reg_dst_o = index, reg_data_o = 0, reg_we_n_o = 0, then increment index.
REQ-024 SHALL, at the edge that issues index 31, return to RUN and register clear_done_o = 1 for exactly one cycle, coincident with the x31 strobe.
REQ-025 SHALL keep busy_o = 1 exactly while state = CLEAR: 31 cycles.
REQ-026 SHALL ignore clear_i while in CLEAR.
REQ-027 SHALL never write any register twice and SHALL never drive a clear write and a requester write in the same cycle.

Reset
REQ-028 SHALL, on rst_i, set state = RUN, reg_we_n_o = 1, reg_dst_o = 0, reg_data_o = 0, busy_o = 0, clear_done_o = 0, index = 1, last-grant = port 1 (port 0 wins the first tie).
REQ-029 SHALL, on rst_i during CLEAR, abort without a clear_done_o pulse; registers already cleared are not restored.
REQ-030 SHALL give rst_i priority over clear_i and all requests in the same cycle.

Structure
REQ-031 SHALL place the state enum, DATA_WIDTH/SELECT_SIZE defaults and REG_COUNT = 32 in shared package reg_sched_pkg.
REQ-032 SHALL implement arbitration in one sub-module, rr_arbiter2 (2-input round-robin, combinational grant, registered pointer).

Verification
REQ-033 SHALL verify single request: wb0 valid, dst = 5, data = 0xBEEFDEAD -> ready0 = 1; next cycle we_n = 0, dst = 5, data = 0xBEEFDEAD.
REQ-034 SHALL verify a tie after reset: both valid for 4 cycles (dst 1 / 2) -> grants 0,1,0,1; strobes on dst 1,2,1,2 in consecutive cycles.
REQ-035 SHALL verify x0 protection: wb1 valid, dst = 0, data = 0x12 -> ready1 = 1; we_n stays 1 the next cycle.
REQ-036 SHALL verify clear: clear_i pulse with wb0 valid in the same cycle -> ready0 = 0; busy 31 cycles; strobes dst 1..31 with data 0; clear_done with dst = 31; wb0 accepted the following cycle.
REQ-037 SHALL verify reset mid-clear: rst_i at index 10 -> next cycle busy = 0, we_n = 1, no clear_done pulse; requests accepted again.

Source files
------------

// File: rtl/reg_sched_pkg.sv
`default_nettype none
// ============================================================================
// Module      : reg_sched_pkg
// Description : Shared types and constants for the register-file write
//               scheduler (state encoding, default widths, register count).
// Revision    : 1.0 - initial release
// ============================================================================
package reg_sched_pkg;

  // Default data word width of the register file.
  localparam int DATA_WIDTH_DEFAULT  = 32;
  // Default register select width (32 architectural registers).
  localparam int SELECT_SIZE_DEFAULT = 5;
  // Number of architectural registers, x0..x31.
  localparam int REG_COUNT           = 32;

  // Scheduler state: normal writeback service or bulk clear of x1..x31.
  typedef enum logic [0:0] {
    ST_RUN   = 1'b0,
    ST_CLEAR = 1'b1
  } sched_state_t;

endpackage : reg_sched_pkg
`default_nettype wire

// File: rtl/rr_arbiter2.sv
`default_nettype none
// ============================================================================
// Module      : rr_arbiter2
// Description : Two-input round-robin arbiter. Grant is combinational from
//               the requests and a registered last-grant pointer; the pointer
//               moves only when the grant is actually taken.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter2 (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [1:0] req_i,
  input  logic       enable_i,
  output logic [1:0] grant_o
);

  // 1 when port 1 was granted last, so port 0 wins the next tie.
  logic r_last;

  // Grant the sole requester, or on a tie the port that did not win last.
  always_comb begin
    grant_o = req_i;
    if (req_i == 2'b11) begin
      grant_o = r_last ? 2'b01 : 2'b10;
    end
  end

  // Remember the winner whenever a grant is consumed.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_last <= 1'b1;
    end else if (enable_i && (req_i != 2'b00)) begin
      r_last <= grant_o[1];
    end
  end

endmodule : rr_arbiter2
`default_nettype wire

// File: rtl/reg_file_write_sched.sv
`default_nettype none
// ============================================================================
// Module      : reg_file_write_sched
// Description : Schedules two writeback requesters (ALU, load) onto a single
//               register-file write port, one write per cycle, and runs a
//               bulk clear of x1..x31 on request. x0 is never written.
// Revision    : 1.0 - initial release
// ============================================================================
module reg_file_write_sched
  import reg_sched_pkg::*;
#(
  parameter int DATA_WIDTH  = DATA_WIDTH_DEFAULT,
  parameter int SELECT_SIZE = SELECT_SIZE_DEFAULT
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   wb0_valid_i,
  input  logic [SELECT_SIZE-1:0] wb0_dst_i,
  input  logic [DATA_WIDTH-1:0]  wb0_data_i,
  output logic                   wb0_ready_o,
  input  logic                   wb1_valid_i,
  input  logic [SELECT_SIZE-1:0] wb1_dst_i,
  input  logic [DATA_WIDTH-1:0]  wb1_data_i,
  output logic                   wb1_ready_o,
  input  logic                   clear_i,
  output logic                   reg_we_n_o,
  output logic [SELECT_SIZE-1:0] reg_dst_o,
  output logic [DATA_WIDTH-1:0]  reg_data_o,
  output logic                   busy_o,
  output logic                   clear_done_o
);

  localparam logic [SELECT_SIZE-1:0] c_FIRST_INDEX = SELECT_SIZE'(1);
  localparam logic [SELECT_SIZE-1:0] c_LAST_INDEX  = SELECT_SIZE'(REG_COUNT - 1);
  localparam logic [SELECT_SIZE-1:0] c_ZERO_REG    = '0;

  sched_state_t            r_state;
  sched_state_t            w_state_next;
  logic [SELECT_SIZE-1:0]  r_index;
  logic [SELECT_SIZE-1:0]  w_index_next;
  logic                    r_we_n;
  logic                    w_we_n_next;
  logic [SELECT_SIZE-1:0]  r_dst;
  logic [SELECT_SIZE-1:0]  w_dst_next;
  logic [DATA_WIDTH-1:0]   r_data;
  logic [DATA_WIDTH-1:0]   w_data_next;
  logic                    r_done;
  logic                    w_done_next;

  logic                    w_enable;
  logic [1:0]              w_grant;
  logic                    w_accept;
  logic [SELECT_SIZE-1:0]  w_sel_dst;
  logic [DATA_WIDTH-1:0]   w_sel_data;

  // Requests are serviceable only in RUN with no clear pending and no reset,
  // so a clear or reset in the same cycle always beats a writeback.
  assign w_enable = (r_state == ST_RUN) && !clear_i && !rst_i;

  rr_arbiter2 u_arb (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .req_i    ({wb1_valid_i, wb0_valid_i}),
    .enable_i (w_enable),
    .grant_o  (w_grant)
  );

  assign wb0_ready_o = w_enable && w_grant[0];
  assign wb1_ready_o = w_enable && w_grant[1];
  assign w_accept    = wb0_ready_o || wb1_ready_o;
  assign w_sel_dst   = w_grant[1] ? wb1_dst_i  : wb0_dst_i;
  assign w_sel_data  = w_grant[1] ? wb1_data_i : wb0_data_i;

  // Next-state and next-output decode; strobe defaults to idle, address and
  // data hold their last values so the register file bus stays quiet.
  always_comb begin
    w_state_next = r_state;
    w_index_next = r_index;
    w_we_n_next  = 1'b1;
    w_dst_next   = r_dst;
    w_data_next  = r_data;
    w_done_next  = 1'b0;
    unique case (r_state)
      ST_RUN: begin
        if (clear_i) begin
          w_state_next = ST_CLEAR;
          w_index_next = c_FIRST_INDEX;
        end else if (w_accept) begin
          w_dst_next  = w_sel_dst;
          w_data_next = w_sel_data;
          // A write to x0 is accepted but never strobed.
          w_we_n_next = (w_sel_dst == c_ZERO_REG);
        end
      end
      ST_CLEAR: begin
        w_dst_next  = r_index;
        w_data_next = '0;
        w_we_n_next = 1'b0;
        if (r_index == c_LAST_INDEX) begin
          w_state_next = ST_RUN;
          w_index_next = c_FIRST_INDEX;
          w_done_next  = 1'b1;
        end else begin
          w_index_next = r_index + c_FIRST_INDEX;
        end
      end
      default: begin
        w_state_next = ST_RUN;
      end
    endcase
  end

  // State and registered register-file bus; reset aborts any clear silently.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= ST_RUN;
      r_index <= c_FIRST_INDEX;
      r_we_n  <= 1'b1;
      r_dst   <= '0;
      r_data  <= '0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_index <= w_index_next;
      r_we_n  <= w_we_n_next;
      r_dst   <= w_dst_next;
      r_data  <= w_data_next;
      r_done  <= w_done_next;
    end
  end

  assign reg_we_n_o   = r_we_n;
  assign reg_dst_o    = r_dst;
  assign reg_data_o   = r_data;
  assign busy_o       = (r_state == ST_CLEAR);
  assign clear_done_o = r_done;

endmodule : reg_file_write_sched
`default_nettype wire

// File: tb/tb_reg_file_write_sched.sv
`default_nettype none
// ============================================================================
// Module      : tb_reg_file_write_sched
// Description : Self-checking bench for reg_file_write_sched: directed
//               scenarios plus randomized traffic against a round-robin model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_reg_file_write_sched;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        wb0_valid_i = 1'b0;
  logic [4:0]  wb0_dst_i = '0;
  logic [31:0] wb0_data_i = '0;
  logic        wb0_ready_o;
  logic        wb1_valid_i = 1'b0;
  logic [4:0]  wb1_dst_i = '0;
  logic [31:0] wb1_data_i = '0;
  logic        wb1_ready_o;
  logic        clear_i = 1'b0;
  logic        reg_we_n_o;
  logic [4:0]  reg_dst_o;
  logic [31:0] reg_data_o;
  logic        busy_o;
  logic        clear_done_o;

  int tests = 0;
  int fails = 0;

  reg_file_write_sched #(.DATA_WIDTH(32), .SELECT_SIZE(5)) dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .wb0_valid_i  (wb0_valid_i),
    .wb0_dst_i    (wb0_dst_i),
    .wb0_data_i   (wb0_data_i),
    .wb0_ready_o  (wb0_ready_o),
    .wb1_valid_i  (wb1_valid_i),
    .wb1_dst_i    (wb1_dst_i),
    .wb1_data_i   (wb1_data_i),
    .wb1_ready_o  (wb1_ready_o),
    .clear_i      (clear_i),
    .reg_we_n_o   (reg_we_n_o),
    .reg_dst_o    (reg_dst_o),
    .reg_data_o   (reg_data_o),
    .busy_o       (busy_o),
    .clear_done_o (clear_done_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic idle_inputs();
    wb0_valid_i = 1'b0;
    wb1_valid_i = 1'b0;
    clear_i     = 1'b0;
  endtask

  task automatic apply_reset();
    rst_i = 1'b1;
    idle_inputs();
    repeat (2) @(posedge clk_i);
    #1 rst_i = 1'b0;
  endtask

  task automatic test_reset();
    rst_i = 1'b1;
    clear_i = 1'b0;
    wb0_valid_i = 1'b1; wb0_dst_i = 5'd4; wb0_data_i = 32'h1;
    wb1_valid_i = 1'b1; wb1_dst_i = 5'd6; wb1_data_i = 32'h2;
    repeat (2) @(posedge clk_i);
    #1;
    tests++; if (wb0_ready_o !== 1'b0 || wb1_ready_o !== 1'b0) begin fails++;
      $display("FAIL reset_ready: got %b%b expected 00", wb0_ready_o, wb1_ready_o); end
    tests++; if (reg_we_n_o !== 1'b1) begin fails++;
      $display("FAIL reset_we_n: got %b expected 1", reg_we_n_o); end
    tests++; if (reg_dst_o !== 5'd0 || reg_data_o !== 32'd0) begin fails++;
      $display("FAIL reset_bus: got dst=%0d data=%h expected 0/0", reg_dst_o, reg_data_o); end
    tests++; if (busy_o !== 1'b0 || clear_done_o !== 1'b0) begin fails++;
      $display("FAIL reset_status: got busy=%b done=%b expected 0/0", busy_o, clear_done_o); end
    idle_inputs();
    rst_i = 1'b0;
  endtask

  task automatic test_tie_after_reset();
    int g;
    apply_reset();
    wb0_valid_i = 1'b1; wb0_dst_i = 5'd1; wb0_data_i = 32'hA0A0_0001;
    wb1_valid_i = 1'b1; wb1_dst_i = 5'd2; wb1_data_i = 32'hB0B0_0002;
    for (int i = 0; i < 4; i++) begin
      g = i % 2;
      #1;
      tests++; if (wb0_ready_o !== (g == 0) || wb1_ready_o !== (g == 1)) begin fails++;
        $display("FAIL tie_grant[%0d]: got r0=%b r1=%b expected port %0d", i, wb0_ready_o, wb1_ready_o, g); end
      @(posedge clk_i); #1;
      tests++; if (reg_we_n_o !== 1'b0 || reg_dst_o !== ((g == 0) ? 5'd1 : 5'd2)) begin fails++;
        $display("FAIL tie_write[%0d]: got we_n=%b dst=%0d expected 0/%0d", i, reg_we_n_o, reg_dst_o, g + 1); end
    end
    idle_inputs();
  endtask

  task automatic test_single();
    wb0_valid_i = 1'b1; wb0_dst_i = 5'd5; wb0_data_i = 32'hBEEF_DEAD;
    #1;
    tests++; if (wb0_ready_o !== 1'b1) begin fails++;
      $display("FAIL single_ready: got %b expected 1", wb0_ready_o); end
    @(posedge clk_i); #1;
    wb0_valid_i = 1'b0;
    tests++; if (reg_we_n_o !== 1'b0 || reg_dst_o !== 5'd5 || reg_data_o !== 32'hBEEF_DEAD) begin fails++;
      $display("FAIL single_write: got we_n=%b dst=%0d data=%h expected 0/5/beefdead", reg_we_n_o, reg_dst_o, reg_data_o); end
    @(posedge clk_i); #1;
    tests++; if (reg_we_n_o !== 1'b1 || reg_dst_o !== 5'd5 || reg_data_o !== 32'hBEEF_DEAD) begin fails++;
      $display("FAIL single_hold: got we_n=%b dst=%0d data=%h expected 1/5/beefdead", reg_we_n_o, reg_dst_o, reg_data_o); end
  endtask

  task automatic test_x0();
    wb1_valid_i = 1'b1; wb1_dst_i = 5'd0; wb1_data_i = 32'h12;
    #1;
    tests++; if (wb1_ready_o !== 1'b1) begin fails++;
      $display("FAIL x0_ready: got %b expected 1", wb1_ready_o); end
    @(posedge clk_i); #1;
    wb1_valid_i = 1'b0;
    tests++; if (reg_we_n_o !== 1'b1) begin fails++;
      $display("FAIL x0_we_n: got %b expected 1", reg_we_n_o); end
  endtask

  task automatic test_clear();
    clear_i = 1'b1;
    wb0_valid_i = 1'b1; wb0_dst_i = 5'd7; wb0_data_i = 32'h55;
    #1;
    tests++; if (wb0_ready_o !== 1'b0) begin fails++;
      $display("FAIL clear_req_ready: got %b expected 0", wb0_ready_o); end
    @(posedge clk_i); #1;
    clear_i = 1'b0;
    tests++; if (busy_o !== 1'b1 || reg_we_n_o !== 1'b1 || wb0_ready_o !== 1'b0) begin fails++;
      $display("FAIL clear_enter: got busy=%b we_n=%b r0=%b expected 1/1/0", busy_o, reg_we_n_o, wb0_ready_o); end
    for (int k = 1; k <= 31; k++) begin
      if (k == 15) clear_i = 1'b1;
      if (k == 16) clear_i = 1'b0;
      @(posedge clk_i); #1;
      tests++;
      if (reg_we_n_o !== 1'b0 || reg_dst_o !== 5'(k) || reg_data_o !== 32'd0 ||
          busy_o !== (k < 31) || clear_done_o !== (k == 31) || wb0_ready_o !== (k == 31)) begin
        fails++;
        $display("FAIL clear_step[%0d]: got we_n=%b dst=%0d data=%h busy=%b done=%b r0=%b expected 0/%0d/0/%b/%b/%b",
                 k, reg_we_n_o, reg_dst_o, reg_data_o, busy_o, clear_done_o, wb0_ready_o, k, k < 31, k == 31, k == 31);
      end
    end
    @(posedge clk_i); #1;
    wb0_valid_i = 1'b0;
    tests++; if (reg_we_n_o !== 1'b0 || reg_dst_o !== 5'd7 || reg_data_o !== 32'h55 || clear_done_o !== 1'b0) begin fails++;
      $display("FAIL clear_after: got we_n=%b dst=%0d data=%h done=%b expected 0/7/55/0", reg_we_n_o, reg_dst_o, reg_data_o, clear_done_o); end
  endtask

  task automatic test_reset_mid_clear();
    int done_seen;
    clear_i = 1'b1;
    @(posedge clk_i); #1;
    clear_i = 1'b0;
    repeat (9) @(posedge clk_i);
    #1;
    tests++; if (reg_dst_o !== 5'd9 || busy_o !== 1'b1) begin fails++;
      $display("FAIL midclr_pos: got dst=%0d busy=%b expected 9/1", reg_dst_o, busy_o); end
    rst_i = 1'b1;
    @(posedge clk_i); #1;
    rst_i = 1'b0;
    tests++; if (busy_o !== 1'b0 || reg_we_n_o !== 1'b1 || clear_done_o !== 1'b0) begin fails++;
      $display("FAIL midclr_abort: got busy=%b we_n=%b done=%b expected 0/1/0", busy_o, reg_we_n_o, clear_done_o); end
    wb1_valid_i = 1'b1; wb1_dst_i = 5'd3; wb1_data_i = 32'hCAFE_0003;
    #1;
    tests++; if (wb1_ready_o !== 1'b1) begin fails++;
      $display("FAIL midclr_ready: got %b expected 1", wb1_ready_o); end
    done_seen = 0;
    @(posedge clk_i); #1;
    wb1_valid_i = 1'b0;
    tests++; if (reg_we_n_o !== 1'b0 || reg_dst_o !== 5'd3 || reg_data_o !== 32'hCAFE_0003) begin fails++;
      $display("FAIL midclr_write: got we_n=%b dst=%0d data=%h expected 0/3/cafe0003", reg_we_n_o, reg_dst_o, reg_data_o); end
    for (int i = 0; i < 30; i++) begin
      if (clear_done_o === 1'b1 || busy_o === 1'b1) done_seen++;
      @(posedge clk_i); #1;
    end
    tests++; if (done_seen != 0) begin fails++;
      $display("FAIL midclr_no_done: got %0d cycles of done/busy expected 0", done_seen); end
  endtask

  // Random traffic versus a model: round-robin on ties, strobe one cycle
  // after acceptance unless the target is x0, bus holds when idle.
  task automatic test_random();
    int          last_port;
    int          exp_port;
    bit          hold_known;
    logic [4:0]  hold_dst;
    logic [31:0] hold_data;
    logic [4:0]  sel_dst;
    logic [31:0] sel_data;
    apply_reset();
    last_port  = 1;
    hold_known = 1'b0;
    hold_dst   = '0;
    hold_data  = '0;
    for (int n = 0; n < 300; n++) begin
      wb0_valid_i = 1'($urandom_range(0, 1));
      wb1_valid_i = 1'($urandom_range(0, 1));
      wb0_dst_i   = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
      wb1_dst_i   = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
      wb0_data_i  = $urandom;
      wb1_data_i  = $urandom;
      if (wb0_valid_i && wb1_valid_i) exp_port = (last_port == 0) ? 1 : 0;
      else if (wb0_valid_i)           exp_port = 0;
      else if (wb1_valid_i)           exp_port = 1;
      else                            exp_port = -1;
      sel_dst  = (exp_port == 1) ? wb1_dst_i  : wb0_dst_i;
      sel_data = (exp_port == 1) ? wb1_data_i : wb0_data_i;
      #1;
      tests++; if (wb0_ready_o !== (exp_port == 0) || wb1_ready_o !== (exp_port == 1)) begin fails++;
        $display("FAIL rand_grant[%0d]: got r0=%b r1=%b expected port %0d", n, wb0_ready_o, wb1_ready_o, exp_port); end
      @(posedge clk_i); #1;
      if (exp_port >= 0) begin
        last_port = exp_port;
        if (sel_dst == 5'd0) begin
          hold_known = 1'b0;
          tests++; if (reg_we_n_o !== 1'b1) begin fails++;
            $display("FAIL rand_x0[%0d]: got we_n=%b expected 1", n, reg_we_n_o); end
        end else begin
          hold_known = 1'b1;
          hold_dst   = sel_dst;
          hold_data  = sel_data;
          tests++; if (reg_we_n_o !== 1'b0 || reg_dst_o !== sel_dst || reg_data_o !== sel_data) begin fails++;
            $display("FAIL rand_write[%0d]: got we_n=%b dst=%0d data=%h expected 0/%0d/%h", n, reg_we_n_o, reg_dst_o, reg_data_o, sel_dst, sel_data); end
        end
      end else begin
        tests++; if (reg_we_n_o !== 1'b1 || (hold_known && (reg_dst_o !== hold_dst || reg_data_o !== hold_data))) begin fails++;
          $display("FAIL rand_idle[%0d]: got we_n=%b dst=%0d data=%h expected 1/%0d/%h", n, reg_we_n_o, reg_dst_o, reg_data_o, hold_dst, hold_data); end
      end
    end
    idle_inputs();
  endtask

  initial begin
    test_reset();
    test_tie_after_reset();
    test_single();
    test_x0();
    test_clear();
    test_reset_mid_clear();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule : tb_reg_file_write_sched
`default_nettype wire
